// File: rtl/memory_stage.sv
// MEM stage of the RV32I pipeline: drives a req/ready data-memory bus with
// store lane generation, load extraction/extension, wait-state stall and bus
// timeout, and owns the MEM/WB pipeline register.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module memory_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [1:0]  Mem_to_RegM,
    input  logic [2:0]  funct3M,
    input  logic [4:0]  RDM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] WriteDataM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic        RegWriteW,
    output logic [1:0]  Mem_to_RegW,
    output logic [4:0]  RDW,
    output logic [31:0] ALUOutW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic        BusErrW,
    output logic        MisalignW
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e      state_q, state_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;

    logic        reg_write_w_q, reg_write_w_d;
    logic [1:0]  mem_to_reg_w_q, mem_to_reg_w_d;
    logic [4:0]  rd_w_q, rd_w_d;
    logic [31:0] alu_out_w_q, alu_out_w_d;
    logic [31:0] read_data_w_q, read_data_w_d;
    logic [31:0] pc_plus4_w_q, pc_plus4_w_d;
    logic        bus_err_w_q, bus_err_w_d;
    logic        misalign_w_d;

    logic [1:0]  a;
    logic        misaligned;
    logic        timeout_hit;
    logic        pending;
    logic        is_load;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;

    // Access qualification: misalignment, timeout abort, request and stall.
    always_comb begin
        a = ALUOutM[1:0];
`ifdef MEM_MISALIGN_TRAP_EN
        misaligned = (MemReadM | MemWriteM) &
                     (((funct3M[1:0] == 2'b01) & a[0]) |
                      ((funct3M[1:0] == 2'b10) & (a != 2'b00)));
`else
        misaligned = 1'b0;
`endif
        timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == StWait) &&
                      (wait_cnt_q == TIMEOUT_CYCLES - 1) && !dmem_ready;
        // The request is withdrawn in the abort cycle; reset kills it asynchronously.
        pending  = rst & (MemReadM | MemWriteM) & ~misaligned & ~timeout_hit;
        dmem_req = pending;
        dmem_we  = MemWriteM;
        StallM   = pending & ~dmem_ready;
        is_load  = MemReadM & ~MemWriteM;
    end

    // Bus address, byte enables and lane-replicated store data.
    always_comb begin
        dmem_addr  = {ALUOutM[31:2], 2'b00};
        dmem_be    = 4'b1111;
        dmem_wdata = WriteDataM;
        if (MemWriteM) begin
            case (funct3M)
                3'b000: begin
                    dmem_be    = 4'b0001 << a;
                    dmem_wdata = {4{WriteDataM[7:0]}};
                end
                3'b001: begin
                    dmem_be    = a[1] ? 4'b1100 : 4'b0011;
                    dmem_wdata = {2{WriteDataM[15:0]}};
                end
                default: begin
                    dmem_be    = 4'b1111;
                    dmem_wdata = WriteDataM;
                end
            endcase
        end
    end

    // Load lane extraction and sign/zero extension.
    always_comb begin
        case (a)
            2'b00:   ld_byte = dmem_rdata[7:0];
            2'b01:   ld_byte = dmem_rdata[15:8];
            2'b10:   ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3M)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_data = {24'h0, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_data = {16'h0, ld_half};
            default: load_data = dmem_rdata;
        endcase
    end

    // Wait-state FSM next state and cycle counter.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pending && !dmem_ready) begin
                    state_d    = StWait;
                    wait_cnt_d = 32'd1;
                end
            end
            StWait: begin
                if (dmem_ready || timeout_hit) begin
                    state_d    = StIdle;
                    wait_cnt_d = 32'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d    = StIdle;
                wait_cnt_d = 32'd0;
            end
        endcase
    end

    // MEM/WB next values: capture on progress, bubble while stalled.
    always_comb begin
        reg_write_w_d  = RegWriteM & ~timeout_hit & ~misaligned;
        mem_to_reg_w_d = Mem_to_RegM;
        rd_w_d         = RDM;
        alu_out_w_d    = ALUOutM;
        pc_plus4_w_d   = PCPlus4M;
        read_data_w_d  = (is_load & ~timeout_hit & ~misaligned) ? load_data : 32'h0;
        bus_err_w_d    = timeout_hit;
        misalign_w_d   = misaligned;
        if (StallM) begin
            reg_write_w_d  = 1'b0;
            bus_err_w_d    = 1'b0;
            misalign_w_d   = 1'b0;
            mem_to_reg_w_d = mem_to_reg_w_q;
            rd_w_d         = rd_w_q;
            alu_out_w_d    = alu_out_w_q;
            pc_plus4_w_d   = pc_plus4_w_q;
            read_data_w_d  = read_data_w_q;
        end
    end

    // State and MEM/WB register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            wait_cnt_q     <= 32'd0;
            reg_write_w_q  <= 1'b0;
            mem_to_reg_w_q <= 2'b00;
            rd_w_q         <= 5'd0;
            alu_out_w_q    <= 32'h0;
            read_data_w_q  <= 32'h0;
            pc_plus4_w_q   <= 32'h0;
            bus_err_w_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            reg_write_w_q  <= reg_write_w_d;
            mem_to_reg_w_q <= mem_to_reg_w_d;
            rd_w_q         <= rd_w_d;
            alu_out_w_q    <= alu_out_w_d;
            read_data_w_q  <= read_data_w_d;
            pc_plus4_w_q   <= pc_plus4_w_d;
            bus_err_w_q    <= bus_err_w_d;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_w_q;

    // Misalignment flag register, only present with the trap enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_w_q <= 1'b0;
        end else begin
            misalign_w_q <= misalign_w_d;
        end
    end

    assign MisalignW = misalign_w_q;
`else
    logic unused_misalign;
    assign unused_misalign = misalign_w_d;
    assign MisalignW       = 1'b0;
`endif

    assign RegWriteW   = reg_write_w_q;
    assign Mem_to_RegW = mem_to_reg_w_q;
    assign RDW         = rd_w_q;
    assign ALUOutW     = alu_out_w_q;
    assign ReadDataW   = read_data_w_q;
    assign PCPlus4W    = pc_plus4_w_q;
    assign BusErrW     = bus_err_w_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage (default build, timeout of 4).
module tb_memory_stage;

    logic        clk;
    logic        rst;
    logic        RegWriteM, MemReadM, MemWriteM;
    logic [1:0]  Mem_to_RegM;
    logic [2:0]  funct3M;
    logic [4:0]  RDM;
    logic [31:0] ALUOutM, PCPlus4M, WriteDataM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        StallM;
    logic        RegWriteW;
    logic [1:0]  Mem_to_RegW;
    logic [4:0]  RDW;
    logic [31:0] ALUOutW, ReadDataW, PCPlus4W;
    logic        BusErrW, MisalignW;

    int checks   = 0;
    int failures = 0;

    memory_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .Mem_to_RegM(Mem_to_RegM), .funct3M(funct3M), .RDM(RDM),
        .ALUOutM(ALUOutM), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .StallM(StallM), .RegWriteW(RegWriteW), .Mem_to_RegW(Mem_to_RegW),
        .RDW(RDW), .ALUOutW(ALUOutW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
        .BusErrW(BusErrW), .MisalignW(MisalignW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic rw, input logic rd_en, input logic wr_en,
                      input logic [2:0] f3, input logic [4:0] rd,
                      input logic [31:0] alu, input logic [31:0] wd);
        RegWriteM  = rw;
        MemReadM   = rd_en;
        MemWriteM  = wr_en;
        funct3M    = f3;
        RDM        = rd;
        ALUOutM    = alu;
        WriteDataM = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        op(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'h0, 32'h0);
        Mem_to_RegM = 2'b00;
        PCPlus4M    = 32'h0;
        dmem_ready  = 1'b0;
        dmem_rdata  = 32'h0;
        step();
        step();
        chk("reset_req", {31'b0, dmem_req}, 32'h0);
        chk("reset_regwrite", {31'b0, RegWriteW}, 32'h0);
        chk("reset_buserr", {31'b0, BusErrW}, 32'h0);
        chk("reset_misalign", {31'b0, MisalignW}, 32'h0);
        chk("reset_readdata", ReadDataW, 32'h0);
        rst = 1'b1;
        step();

        // SB to 0x102, zero-wait
        op(1'b0, 1'b0, 1'b1, 3'b000, 5'd0, 32'h0000_0102, 32'h0000_00AB);
        dmem_ready = 1'b1;
        #1;
        chk("sb_req", {31'b0, dmem_req}, 32'h1);
        chk("sb_we", {31'b0, dmem_we}, 32'h1);
        chk("sb_be", {28'b0, dmem_be}, 32'h4);
        chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
        chk("sb_addr", dmem_addr, 32'h0000_0100);
        chk("sb_stall", {31'b0, StallM}, 32'h0);
        step();

        // SH to 0x06 selects the upper half
        op(1'b0, 1'b0, 1'b1, 3'b001, 5'd0, 32'h0000_0006, 32'h1234_CAFE);
        #1;
        chk("sh_be", {28'b0, dmem_be}, 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hCAFE_CAFE);
        chk("sh_addr", dmem_addr, 32'h0000_0004);
        step();

        // LB from 0x203 with three wait cycles
        op(1'b1, 1'b1, 1'b0, 3'b000, 5'd5, 32'h0000_0203, 32'h0);
        dmem_ready = 1'b0;
        dmem_rdata = 32'h80FF_1234;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lb_stall", {31'b0, StallM}, 32'h1);
            chk("lb_load_be", {28'b0, dmem_be}, 32'hF);
            step();
            chk("lb_bubble_regwrite", {31'b0, RegWriteW}, 32'h0);
        end
        dmem_ready = 1'b1;
        #1;
        chk("lb_stall_release", {31'b0, StallM}, 32'h0);
        step();
        chk("lb_readdata", ReadDataW, 32'hFFFF_FF80);
        chk("lb_regwrite", {31'b0, RegWriteW}, 32'h1);
        chk("lb_rd", {27'b0, RDW}, 32'd5);
        chk("lb_buserr", {31'b0, BusErrW}, 32'h0);

        // LHU from 0x12, zero-wait, with pass-through fields
        op(1'b1, 1'b1, 1'b0, 3'b101, 5'd9, 32'h0000_0012, 32'h0);
        Mem_to_RegM = 2'b01;
        PCPlus4M    = 32'h0000_1004;
        dmem_rdata  = 32'hBEEF_0000;
        #1;
        chk("lhu_stall", {31'b0, StallM}, 32'h0);
        step();
        chk("lhu_readdata", ReadDataW, 32'h0000_BEEF);
        chk("lhu_memtoreg", {30'b0, Mem_to_RegW}, 32'h1);
        chk("lhu_pcplus4", PCPlus4W, 32'h0000_1004);
        chk("lhu_aluout", ALUOutW, 32'h0000_0012);

        // LH sign extension from the lower half
        op(1'b1, 1'b1, 1'b0, 3'b001, 5'd9, 32'h0000_0010, 32'h0);
        dmem_rdata = 32'h0000_8001;
        step();
        chk("lh_readdata", ReadDataW, 32'hFFFF_8001);

        // LW that never gets ready: timeout after three stall cycles
        op(1'b1, 1'b1, 1'b0, 3'b010, 5'd3, 32'h0000_0040, 32'h0);
        dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("to_stall", {31'b0, StallM}, 32'h1);
            step();
        end
        #1;
        chk("to_stall_drop", {31'b0, StallM}, 32'h0);
        chk("to_req_drop", {31'b0, dmem_req}, 32'h0);
        step();
        chk("to_buserr", {31'b0, BusErrW}, 32'h1);
        chk("to_regwrite", {31'b0, RegWriteW}, 32'h0);
        chk("to_readdata", ReadDataW, 32'h0);

        // Following ALU instruction proceeds normally
        op(1'b1, 1'b0, 1'b0, 3'b000, 5'd7, 32'h0000_0055, 32'h0);
        #1;
        chk("alu_stall", {31'b0, StallM}, 32'h0);
        chk("alu_req", {31'b0, dmem_req}, 32'h0);
        step();
        chk("alu_regwrite", {31'b0, RegWriteW}, 32'h1);
        chk("alu_aluout", ALUOutW, 32'h0000_0055);
        chk("alu_buserr", {31'b0, BusErrW}, 32'h0);

        // LW to 0x101 with the trap disabled: plain word read of 0x100
        op(1'b1, 1'b1, 1'b0, 3'b010, 5'd4, 32'h0000_0101, 32'h0);
        dmem_ready = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("lw_mis_req", {31'b0, dmem_req}, 32'h1);
        chk("lw_mis_addr", dmem_addr, 32'h0000_0100);
        step();
        chk("lw_mis_readdata", ReadDataW, 32'hDEAD_BEEF);
        chk("lw_mis_flag", {31'b0, MisalignW}, 32'h0);

        // Reset asserted while waiting
        op(1'b1, 1'b1, 1'b0, 3'b010, 5'd6, 32'h0000_0080, 32'h0);
        dmem_ready = 1'b0;
        step();
        step();
        #1;
        chk("rw_stall_before", {31'b0, StallM}, 32'h1);
        rst = 1'b0;
        #1;
        chk("rw_req", {31'b0, dmem_req}, 32'h0);
        chk("rw_aluout", ALUOutW, 32'h0);
        chk("rw_readdata", ReadDataW, 32'h0);
        chk("rw_rd", {27'b0, RDW}, 32'h0);
        step();
        rst = 1'b1;
        // Fresh access must get the full three stall cycles again
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rw_stall_after", {31'b0, StallM}, 32'h1);
            step();
        end
        #1;
        chk("rw_timeout", {31'b0, StallM}, 32'h0);
        step();
        chk("rw_buserr", {31'b0, BusErrW}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
